// File: rtl/change_dispenser.sv
// Coin payout engine: pays a change amount with ₹10 coins first, then ₹5 coins,
// one hopper handshake per coin, while tracking a live inventory of each coin type.
module change_dispenser #(
    parameter int AMT_W   = 5,
    parameter int CNT_W   = 6,
    parameter int INIT_5  = 20,
    parameter int INIT_10 = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chg_valid,
    input  logic [AMT_W-1:0] chg_amt,
    output logic             chg_ready,
    output logic             coin_req,
    output logic             coin_sel,
    input  logic             coin_ack,
    input  logic             refill_valid,
    input  logic [CNT_W-1:0] refill_5,
    input  logic [CNT_W-1:0] refill_10,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] cnt5,
    output logic [CNT_W-1:0] cnt10
);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        REQ,
        DONE
    } state_t;

    localparam logic [AMT_W-1:0] FIVE = AMT_W'(5);
    localparam logic [AMT_W-1:0] TEN  = AMT_W'(10);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t state;

    // Inventory add that clamps at the counter's full-scale value.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // NOTE: every register here, including the handshake outputs, is state; all use <= so
    // each branch reads the values from before the edge, never a half-updated mix.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            chg_ready <= 1'b1;
            busy      <= 1'b0;
            coin_req  <= 1'b0;
            coin_sel  <= 1'b0;
            done      <= 1'b0;
            short     <= 1'b0;
            remaining <= '0;
            cnt5      <= CNT_W'(INIT_5);
            cnt10     <= CNT_W'(INIT_10);
        end else begin
            case (state)
                IDLE: begin
                    if (refill_valid) begin
                        cnt5  <= sat_add(cnt5, refill_5);
                        cnt10 <= sat_add(cnt10, refill_10);
                    end
                    if (chg_valid) begin
                        remaining <= chg_amt;
                        chg_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SELECT;
                    end
                end
                SELECT: begin
                    if (remaining >= TEN && cnt10 != '0) begin
                        coin_sel <= 1'b1;
                        coin_req <= 1'b1;
                        state    <= REQ;
                    end else if (remaining >= FIVE && cnt5 != '0) begin
                        coin_sel <= 1'b0;
                        coin_req <= 1'b1;
                        state    <= REQ;
                    end else begin
                        done  <= 1'b1;
                        short <= (remaining != '0);
                        state <= DONE;
                    end
                end
                REQ: begin
                    // Inventory and amount move only when the hopper confirms ejection.
                    if (coin_ack) begin
                        if (coin_sel) begin
                            cnt10     <= cnt10 - ONE;
                            remaining <= remaining - TEN;
                        end else begin
                            cnt5      <= cnt5 - ONE;
                            remaining <= remaining - FIVE;
                        end
                        coin_req <= 1'b0;
                        state    <= SELECT;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    short     <= 1'b0;
                    chg_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench for change_dispenser against a greedy arithmetic
// model of coin payout, inventory and handshake latency.
module tb_change_dispenser;

    localparam int AMT_W = 5;
    localparam int CNT_W = 6;
    localparam int CMAX  = 63;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             chg_valid = 1'b0;
    logic [AMT_W-1:0] chg_amt = '0;
    logic             chg_ready;
    logic             coin_req;
    logic             coin_sel;
    logic             coin_ack = 1'b0;
    logic             refill_valid = 1'b0;
    logic [CNT_W-1:0] refill_5 = '0;
    logic [CNT_W-1:0] refill_10 = '0;
    logic             busy;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] remaining;
    logic [CNT_W-1:0] cnt5;
    logic [CNT_W-1:0] cnt10;

    int n_checks = 0;
    int n_errors = 0;
    int m5 = 20;
    int m10 = 20;

    change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_5(20), .INIT_10(20)) dut (
        .clk(clk), .rst(rst), .chg_valid(chg_valid), .chg_amt(chg_amt),
        .chg_ready(chg_ready), .coin_req(coin_req), .coin_sel(coin_sel),
        .coin_ack(coin_ack), .refill_valid(refill_valid), .refill_5(refill_5),
        .refill_10(refill_10), .busy(busy), .done(done), .short(short),
        .remaining(remaining), .cnt5(cnt5), .cnt10(cnt10)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // One change request: optional refill at accept, optional refill pulse while busy,
    // hopper acks each coin after `delay` extra cycles.
    task automatic run(input int amt, input int delay, input bit rv, input int r5,
                       input int r10, input bit busy_refill);
        int e10, e5, rem, cyc, waited, n10, n5, done_cyc;
        bit got_done, order_bad, stable_bad, held_sel;
        if (rv) begin
            m5  = sat(m5 + r5);
            m10 = sat(m10 + r10);
        end
        rem = amt;
        e10 = rem / 10;
        if (e10 > m10) e10 = m10;
        rem -= 10 * e10;
        e5 = rem / 5;
        if (e5 > m5) e5 = m5;
        rem -= 5 * e5;
        m10 -= e10;
        m5  -= e5;

        check("ready_before", chg_ready, 1);
        chg_valid    = 1'b1;
        chg_amt      = AMT_W'(amt);
        refill_valid = rv;
        refill_5     = CNT_W'(r5);
        refill_10    = CNT_W'(r10);
        cyc = 0; waited = 0; n10 = 0; n5 = 0; done_cyc = 0;
        got_done = 0; order_bad = 0; stable_bad = 0; held_sel = 0;
        while (cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                chg_valid    = 1'b0;
                refill_valid = 1'b0;
            end
            if (coin_ack) coin_ack = 1'b0;
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
                break;
            end
            if (busy_refill && cyc == 2) begin
                refill_valid = 1'b1;
                refill_5     = CNT_W'(7);
                refill_10    = CNT_W'(7);
            end else if (busy_refill && cyc == 3) begin
                refill_valid = 1'b0;
            end
            if (coin_req) begin
                if (waited == 0) begin
                    held_sel = coin_sel;
                    if (coin_sel) begin
                        n10++;
                        if (n5 > 0) order_bad = 1;
                    end else begin
                        n5++;
                    end
                end else if (coin_sel != held_sel) begin
                    stable_bad = 1;
                end
                if (waited == delay) begin
                    coin_ack = 1'b1;
                    waited = 0;
                end else begin
                    waited++;
                end
            end
        end
        refill_valid = 1'b0;
        coin_ack     = 1'b0;
        check("done_seen", got_done, 1);
        check("coins10", n10, e10);
        check("coins5", n5, e5);
        check("order_10_first", order_bad, 0);
        check("sel_stable", stable_bad, 0);
        check("done_cycle", done_cyc, (delay + 2) * (e10 + e5) + 2);
        check("short", short, (rem != 0));
        check("busy_at_done", busy, 1);
        check("remaining", remaining, rem);
        check("cnt5", cnt5, m5);
        check("cnt10", cnt10, m10);
        @(posedge clk); #1;
        check("done_pulse_end", done, 0);
        check("short_pulse_end", short, 0);
        check("ready_after", chg_ready, 1);
        check("remaining_hold", remaining, rem);
    endtask

    task automatic idle_refill(input int r5, input int r10);
        m5  = sat(m5 + r5);
        m10 = sat(m10 + r10);
        refill_valid = 1'b1;
        refill_5     = CNT_W'(r5);
        refill_10    = CNT_W'(r10);
        @(posedge clk); #1;
        refill_valid = 1'b0;
        check("refill_cnt5", cnt5, m5);
        check("refill_cnt10", cnt10, m10);
    endtask

    initial begin
        int guard;
        bit seen;
        #12;
        check("rst_ready", chg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_coin_req", coin_req, 0);
        check("rst_coin_sel", coin_sel, 0);
        check("rst_done", done, 0);
        check("rst_short", short, 0);
        check("rst_remaining", remaining, 0);
        check("rst_cnt5", cnt5, 20);
        check("rst_cnt10", cnt10, 20);
        rst = 1'b1;
        @(posedge clk); #1;

        run(15, 0, 0, 0, 0, 0);
        run(7, 0, 0, 0, 0, 0);
        run(0, 0, 0, 0, 0, 0);
        run(23, 3, 0, 0, 0, 0);
        run(15, 1, 0, 0, 0, 1);

        // Exhaust ₹10 coins so the payout must fall back to ₹5 coins.
        guard = 0;
        while (m10 > 0 && guard < 20) begin
            run(20, 0, 0, 0, 0, 0);
            guard++;
        end
        run(20, 0, 0, 0, 0, 0);
        guard = 0;
        while (m5 > 1 && guard < 40) begin
            run(5, 0, 0, 0, 0, 0);
            guard++;
        end
        run(15, 0, 0, 0, 0, 0);
        run(15, 0, 0, 0, 0, 0);

        idle_refill(40, 40);
        run(10, 0, 1, 40, 40, 0);

        for (int i = 0; i < 40; i++) begin
            run($urandom_range(0, 31), $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset while a coin is outstanding.
        chg_valid = 1'b1;
        chg_amt   = AMT_W'(10);
        @(posedge clk); #1;
        chg_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (coin_req) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("req_before_rst", seen, 1);
        #2 rst = 1'b0;
        #1;
        check("async_coin_req", coin_req, 0);
        check("async_ready", chg_ready, 1);
        @(posedge clk); #3;
        rst = 1'b1;
        m5 = 20;
        m10 = 20;
        @(posedge clk); #1;
        check("post_rst_ready", chg_ready, 1);
        check("post_rst_cnt5", cnt5, 20);
        check("post_rst_cnt10", cnt10, 20);
        check("post_rst_done", done, 0);
        check("post_rst_short", short, 0);
        run(15, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
